// File: rtl/four_to_one_rr_arbiter.sv
// ============================================================================
// four_to_one_rr_arbiter : 4-source round-robin arbiter with bounded tenures
// driving a 4:1 mux select and a valid/ready handshake. Optional macro
// ARB_STATS_EN adds per-source tenure-start counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module four_to_one_rr_arbiter #(
  parameter int MAX_BURST = 4
`ifdef ARB_STATS_EN
  ,
  parameter int STAT_W    = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       last_i,
  output logic [1:0] sel_o,
  output logic [3:0] gnt_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       busy_o
`ifdef ARB_STATS_EN
  ,
  input  logic                   stat_clr_i,
  output logic [3:0][STAT_W-1:0] gnt_cnt_o
`endif
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t            state_q;
  logic [1:0]        sel_q;
  logic [1:0]        ptr_q;
  logic [3:0]        gnt_q;
  logic [BEAT_W-1:0] beat_q;

  logic       busy;
  logic       cur_req;
  logic       xfer;
  logic       rel;
  logic       start;
  logic [1:0] base;
  logic [1:0] win_d;

  // First requester after 'base' in rotating order; 'base' itself is last.
  function automatic logic [1:0] f_pick(input logic [1:0] b, input logic [3:0] r);
    logic [1:0] idx;
    f_pick = b;
    for (int i = 4; i >= 1; i--) begin
      idx = b + 2'(i);
      if (r[idx]) f_pick = idx;
    end
  endfunction

  assign busy    = (state_q == S_GRANT);
  assign cur_req = req_i[sel_q];
  assign xfer    = busy && cur_req && out_ready_i;
  assign rel     = busy && (!cur_req || (xfer && (last_i || (beat_q == LAST_BEAT))));
  assign base    = busy ? sel_q : ptr_q;
  assign win_d   = f_pick(base, req_i);
  assign start   = (|req_i) && (!busy || rel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 2'b00;
      ptr_q   <= 2'd3;
      gnt_q   <= 4'b0000;
      beat_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_GRANT;
            sel_q   <= win_d;
            gnt_q   <= 4'b0001 << win_d;
            beat_q  <= '0;
          end
        end
        S_GRANT: begin
          if (rel) begin
            ptr_q  <= sel_q;
            beat_q <= '0;
            if (|req_i) begin
              sel_q <= win_d;
              gnt_q <= 4'b0001 << win_d;
            end else begin
              // sel_q intentionally holds so the mux select stays quiet in idle
              state_q <= S_IDLE;
              gnt_q   <= 4'b0000;
            end
          end else if (xfer) begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign sel_o       = sel_q;
  assign gnt_o       = gnt_q;
  assign busy_o      = busy;
  assign out_valid_o = busy && cur_req;

`ifdef ARB_STATS_EN
  logic [3:0][STAT_W-1:0] cnt_q;

  for (genvar g = 0; g < 4; g++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[g] <= '0;
      end else if (stat_clr_i) begin
        cnt_q[g] <= '0;
      end else if (start && (win_d == 2'(g)) && (cnt_q[g] != {STAT_W{1'b1}})) begin
        cnt_q[g] <= cnt_q[g] + STAT_W'(1);
      end
    end
  end

  assign gnt_cnt_o = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_four_to_one_rr_arbiter.sv
// Directed bench for four_to_one_rr_arbiter (MAX_BURST=4; STAT_W=2 when ARB_STATS_EN).
`default_nettype none

module tb_four_to_one_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_i;
  logic       last_i;
  logic [1:0] sel_o;
  logic [3:0] gnt_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       busy_o;
`ifdef ARB_STATS_EN
  logic            stat_clr_i;
  logic [3:0][1:0] gnt_cnt_o;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  four_to_one_rr_arbiter #(
    .MAX_BURST(4)
`ifdef ARB_STATS_EN
    , .STAT_W(2)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .last_i     (last_i),
    .sel_o      (sel_o),
    .gnt_o      (gnt_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o)
`ifdef ARB_STATS_EN
    , .stat_clr_i(stat_clr_i)
    , .gnt_cnt_o (gnt_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_i       = 4'b0000;
    last_i      = 1'b0;
    out_ready_i = 1'b0;
`ifdef ARB_STATS_EN
    stat_clr_i  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] e_gnt;

    // Reset state, then full rotation with 4-beat tenures
    do_reset();
    #1;
    chk("rst_sel",   32'(sel_o),       32'd0);
    chk("rst_gnt",   32'(gnt_o),       32'd0);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_busy",  32'(busy_o),      32'd0);
    req_i = 4'b1111; out_ready_i = 1'b1;
    tick();
    for (int k = 0; k < 17; k++) begin
      #1;
      e_gnt = 4'b0001 << ((k / 4) % 4);
      chk("rot_gnt",   32'(gnt_o),       32'(e_gnt));
      chk("rot_sel",   32'(sel_o),       32'((k / 4) % 4));
      chk("rot_valid", 32'(out_valid_o), 32'd1);
      tick();
    end

    // Single source with last on beat 2, then withdrawal to idle
    do_reset();
    req_i = 4'b0100; out_ready_i = 1'b1;
    tick();
    #1;
    chk("last_gnt0", 32'(gnt_o), 32'h4);
    chk("last_sel0", 32'(sel_o), 32'd2);
    tick();
    last_i = 1'b1;
    #1;
    chk("last_gnt1", 32'(gnt_o),       32'h4);
    chk("last_val1", 32'(out_valid_o), 32'd1);
    tick();
    req_i = 4'b0000; last_i = 1'b0;
    #1;
    chk("last_gnt2",  32'(gnt_o),       32'h4);
    chk("last_val2",  32'(out_valid_o), 32'd0);
    chk("last_busy2", 32'(busy_o),      32'd1);
    tick();
    #1;
    chk("idle_gnt",  32'(gnt_o),       32'h0);
    chk("idle_busy", 32'(busy_o),      32'd0);
    chk("idle_sel",  32'(sel_o),       32'd2);
    chk("idle_val",  32'(out_valid_o), 32'd0);

    // Stall of 10 cycles on source 1; beat count must survive the stall
    do_reset();
    req_i = 4'b0010; out_ready_i = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("stall_sel", 32'(sel_o),       32'd1);
      chk("stall_gnt", 32'(gnt_o),       32'h2);
      chk("stall_val", 32'(out_valid_o), 32'd1);
      tick();
    end
    req_i = 4'b0011; out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("post_stall_gnt", 32'(gnt_o), 32'h2);
      tick();
    end
    #1;
    chk("post_stall_rot", 32'(gnt_o), 32'h1);
    chk("post_stall_sel", 32'(sel_o), 32'd0);

    // Granted source 3 withdraws while source 0 requests
    do_reset();
    req_i = 4'b1000; out_ready_i = 1'b1;
    tick();
    req_i = 4'b0001;
    #1;
    chk("wd_gnt",   32'(gnt_o),       32'h8);
    chk("wd_valid", 32'(out_valid_o), 32'd0);
    tick();
    #1;
    chk("wd_newgnt", 32'(gnt_o),       32'h1);
    chk("wd_newsel", 32'(sel_o),       32'd0);
    chk("wd_newval", 32'(out_valid_o), 32'd1);

    // Simultaneous last and burst limit: one rotation only
    do_reset();
    req_i = 4'b0011; out_ready_i = 1'b1;
    tick(); tick(); tick(); tick();
    last_i = 1'b1;
    #1;
    chk("lim_gnt0", 32'(gnt_o), 32'h1);
    tick();
    last_i = 1'b0;
    #1;
    chk("lim_gnt1", 32'(gnt_o), 32'h2);

    // Asynchronous reset mid-tenure on beat 2
    do_reset();
    req_i = 4'b1111; out_ready_i = 1'b1;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt",   32'(gnt_o),       32'h0);
    chk("ar_valid", 32'(out_valid_o), 32'd0);
    chk("ar_busy",  32'(busy_o),      32'd0);
    chk("ar_sel",   32'(sel_o),       32'd0);
    req_i = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    chk("ar_regnt", 32'(gnt_o), 32'h2);
    chk("ar_resel", 32'(sel_o), 32'd1);

`ifdef ARB_STATS_EN
    // Three tenures of source 2, clear coincident with a fourth, then saturation
    do_reset();
    req_i = 4'b0100; last_i = 1'b1; out_ready_i = 1'b1;
    tick(); tick(); tick();
    req_i = 4'b0000;
    #1;
    chk("st_cnt3", 32'(gnt_cnt_o[2]), 32'd3);
    chk("st_cnt0", 32'(gnt_cnt_o[0]), 32'd0);
    tick();
    req_i = 4'b0100; stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0; req_i = 4'b0000;
    #1;
    chk("st_clr", 32'(gnt_cnt_o[2]), 32'd0);
    tick();
    req_i = 4'b0100;
    repeat (5) tick();
    req_i = 4'b0000;
    #1;
    chk("st_sat", 32'(gnt_cnt_o[2]), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
